// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-port read to Ram, head-of-queue handshake to
// decode/ALU, and the branch redirect path.
interface instr_fetch_unit_if;
    logic        fetch_req;
    logic [15:0] fetch_address;
    logic [31:0] fetch_out;
    logic [31:0] instr_to_alu;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_out;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output fetch_req, fetch_address, instr_to_alu, instr_valid, pc_out, halted,
        input  fetch_out, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  fetch_req, fetch_address, instr_to_alu, instr_valid, pc_out, halted,
        output fetch_out, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps a 2-entry {instr, pc} queue fed by a
// 1-cycle-latency Ram port, with redirect flush and halt-word detection.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_inflight;
    logic [15:0] r_inflight_pc;
    logic [31:0] r_fifo_instr [2];
    logic [15:0] r_fifo_pc    [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_halted;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_fetch;
    logic [1:0]  w_occ;
    logic [31:0] w_head_instr;
    logic        w_halt_in;
    logic        w_halt_pop;

    assign w_valid      = (r_count != 2'd0);
    assign w_pop        = w_valid && bus.instr_ready;
    assign w_occ        = r_count + {1'b0, r_inflight};
    assign w_head_instr = r_fifo_instr[r_rd_ptr];

    // A fetch may be issued into a full budget only when a slot frees this cycle.
    assign w_fetch = !rst && !bus.redirect && (r_state == FETCH) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    // Responses are only kept while still fetching; after the halt word they are dropped.
    assign w_push     = r_inflight && (r_state == FETCH);
    assign w_halt_in  = w_push && (bus.fetch_out == HALT_WORD);
    assign w_halt_pop = (r_state == DRAIN) && w_pop && (w_head_instr == HALT_WORD);

    assign bus.fetch_req     = w_fetch;
    assign bus.fetch_address = r_pc;
    assign bus.instr_valid   = w_valid;
    assign bus.instr_to_alu  = w_valid ? w_head_instr : 32'h0;
    assign bus.pc_out        = w_valid ? r_fifo_pc[r_rd_ptr] : 16'h0;
    assign bus.halted        = r_halted;

    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            r_state    <= FETCH;
            r_pc       <= rst ? RESET_PC : bus.redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_fetch;
            if (w_fetch)
                r_pc <= r_pc + 16'd1;
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                FETCH: if (w_halt_in) r_state <= DRAIN;
                DRAIN: if (w_halt_pop) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fetch)
            r_inflight_pc <= r_pc;
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.fetch_out;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end
endmodule
